// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT power-spectrum frame sequencer.
// Frame size, bin count, counter widths and the controller state encoding live here.
package fft_pkg;

   localparam int FFT_N = 256;
   localparam int NBINS = 129;
   localparam int F32_W = 32;

   // One extra bit so a counter can hold the full-frame value FFT_N.
   localparam int CNT_W = $clog2(FFT_N) + 1;
   localparam int BIN_W = $clog2(FFT_N);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FFT_N);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FFT_N - 1);
   localparam logic [CNT_W-1:0] CNT_NBINS = CNT_W'(NBINS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry skid FIFO with fall-through: when empty, the input is presented at the head
// in the same cycle, so a freshly read sample reaches the pipeline without an extra stage.
module fft_skid_fifo
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic [F32_W-1:0] in_data_i,
   output logic             out_valid_o,
   output logic [F32_W-1:0] out_data_o,
   input  logic             out_ready_i,
   output logic [1:0]       occ_o
);

   logic [F32_W-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic             empty;
   logic             store;
   logic             pop_mem;

   assign empty   = (occ_q == 2'd0);
   // Input is stored unless it bypasses straight through an empty FIFO into a ready sink.
   assign store   = in_valid_i && (!empty || !out_ready_i);
   assign pop_mem = out_ready_i && !empty;

   assign out_valid_o = !empty || in_valid_i;
   assign occ_o       = occ_q;

   always_comb begin
      // NOTE: defaults first in every always_comb so no path leaves a variable unassigned (no latch).
      out_data_o = '0;
      if (!empty) begin
         out_data_o = mem_q[rd_ptr_q];
      end else if (in_valid_i) begin
         out_data_o = in_data_i;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         occ_d    = 2'd0;
      end else begin
         if (store) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop_mem) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         unique case ({store, pop_mem})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // NOTE: data storage has no reset; occupancy alone decides whether an entry is meaningful.
   always_ff @(posedge clk) begin
      if (store && !flush_i) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: streams one FFT_N-sample frame from the circular sample RAM into the
// power-spectrum pipeline and writes bins 0..NBINS-1 of the returned spectrum to the power RAM.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              hclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] rd_base,
   output logic              busy,
   output logic              done,
   output logic              err_last,
   output logic              err_stray,
   output logic [15:0]       frame_cnt,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data,
   output logic [31:0]       fft_data,
   output logic              fft_valid,
   input  logic              fft_ready,
   input  logic [31:0]       pw_data,
   input  logic              pw_valid,
   input  logic              pw_last,
   output logic              pw_ready,
   output logic              pw_we,
   output logic [7:0]        pw_addr,
   output logic [31:0]       pw_wdata
);

   ctrl_state_t       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]  feed_cnt_q, feed_cnt_d;
   logic [CNT_W-1:0]  bin_cnt_q, bin_cnt_d;
   logic              inflight_q;
   logic              done_q, done_d;
   logic              err_last_q, err_last_d;
   logic              err_stray_q, err_stray_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic [1:0]        fifo_occ;
   logic              in_frame;
   logic              start_ok;
   logic              fft_acc;
   logic              bin_in_frame;
   logic              bin_last_idx;

   assign in_frame     = (state_q != ST_IDLE);
   assign start_ok     = start && !abort && (state_q == ST_IDLE);
   assign fft_acc      = fft_valid && fft_ready;
   assign bin_in_frame = pw_valid && in_frame;
   assign bin_last_idx = (bin_cnt_q == CNT_LAST);

   // Credit check counts the read still in flight so the FIFO can never be overrun.
   assign rd_en   = (state_q == ST_FEED) && !abort && (rd_cnt_q < CNT_FULL) &&
                    ((fifo_occ + {1'b0, inflight_q}) < 2'd2);
   assign rd_addr = base_q + ADDR_W'(rd_cnt_q);

   fft_skid_fifo u_skid (
      .clk         (hclk),
      .rst_n       (rst_n),
      .flush_i     (abort),
      .in_valid_i  (inflight_q),
      .in_data_i   (rd_data),
      .out_valid_o (fft_valid),
      .out_data_o  (fft_data),
      .out_ready_i (fft_ready),
      .occ_o       (fifo_occ)
   );

   assign pw_ready = 1'b1;
   assign pw_we    = bin_in_frame && (bin_cnt_q < CNT_NBINS);
   assign pw_addr  = pw_we ? bin_cnt_q[BIN_W-1:0] : '0;
   assign pw_wdata = pw_we ? pw_data : '0;

   assign busy      = in_frame;
   assign done      = done_q;
   assign err_last  = err_last_q;
   assign err_stray = err_stray_q;
   assign frame_cnt = frame_cnt_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      rd_cnt_d    = rd_cnt_q;
      feed_cnt_d  = feed_cnt_q;
      bin_cnt_d   = bin_cnt_q;
      err_last_d  = err_last_q;
      err_stray_d = err_stray_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d     = ST_FEED;
               base_d      = rd_base;
               rd_cnt_d    = '0;
               feed_cnt_d  = '0;
               bin_cnt_d   = '0;
               err_last_d  = 1'b0;
               err_stray_d = 1'b0;
            end
         end
         ST_FEED: begin
            if (rd_en) begin
               rd_cnt_d = rd_cnt_q + CNT_ONE;
            end
            if (fft_acc) begin
               feed_cnt_d = feed_cnt_q + CNT_ONE;
               if (feed_cnt_q == CNT_LAST) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The frame ends on the bin count, whatever pw_last says.
            if (bin_in_frame && bin_last_idx) begin
               state_d     = ST_IDLE;
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bin_in_frame) begin
         bin_cnt_d = bin_cnt_q + CNT_ONE;
         if (pw_last != bin_last_idx) begin
            err_last_d = 1'b1;
         end
      end
      if (pw_valid && !in_frame) begin
         err_stray_d = 1'b1;
      end

      if (abort) begin
         state_d     = ST_IDLE;
         rd_cnt_d    = '0;
         feed_cnt_d  = '0;
         bin_cnt_d   = '0;
         done_d      = 1'b0;
         frame_cnt_d = frame_cnt_q;
      end
   end

   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         rd_cnt_q    <= '0;
         feed_cnt_q  <= '0;
         bin_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
         err_last_q  <= 1'b0;
         err_stray_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         rd_cnt_q    <= rd_cnt_d;
         feed_cnt_q  <= feed_cnt_d;
         bin_cnt_q   <= bin_cnt_d;
         inflight_q  <= rd_en;
         done_q      <= done_d;
         err_last_q  <= err_last_d;
         err_stray_q <= err_stray_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: table of frame scenarios plus hand-written abort,
// start-collision and asynchronous-reset sequences, with sample and bin scoreboards.
module tb_fft_frame_ctrl;
   import fft_pkg::*;

   localparam int ADDR_W = 10;

   logic              hclk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] rd_base;
   logic              busy;
   logic              done;
   logic              err_last;
   logic              err_stray;
   logic [15:0]       frame_cnt;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data = '0;
   logic [31:0]       fft_data;
   logic              fft_valid;
   logic              fft_ready;
   logic [31:0]       pw_data;
   logic              pw_valid;
   logic              pw_last;
   logic              pw_ready;
   logic              pw_we;
   logic [7:0]        pw_addr;
   logic [31:0]       pw_wdata;

   fft_frame_ctrl #(.ADDR_W(ADDR_W)) dut (
      .hclk      (hclk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .rd_base   (rd_base),
      .busy      (busy),
      .done      (done),
      .err_last  (err_last),
      .err_stray (err_stray),
      .frame_cnt (frame_cnt),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .fft_data  (fft_data),
      .fft_valid (fft_valid),
      .fft_ready (fft_ready),
      .pw_data   (pw_data),
      .pw_valid  (pw_valid),
      .pw_last   (pw_last),
      .pw_ready  (pw_ready),
      .pw_we     (pw_we),
      .pw_addr   (pw_addr),
      .pw_wdata  (pw_wdata)
   );

   always #5 hclk = ~hclk;

   // Sample RAM: each word holds its own address, returned one cycle after rd_en.
   always @(posedge hclk) begin
      if (rd_en) rd_data <= 32'(rd_addr);
   end

   typedef struct {
      logic [ADDR_W-1:0] base;
      bit                rnd;
      int                last_mode;   // 0: last on 255, 1: last on 200, 2: no last
      bit                mid_start;
      bit                exp_err;
   } vec_t;

   vec_t        vecs[6];
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   int          we_cnt   = 0;
   int          exp_frames = 0;
   bit          rnd_ready = 1'b0;
   logic [31:0] exp_samp[$];
   logic [39:0] exp_bin[$];
   logic [39:0] mon_bin;
   logic [31:0] mon_samp;
   bit          stall_q = 1'b0;
   logic [31:0] stall_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      fft_ready = 1'b1;
      forever begin
         @(posedge hclk);
         #1;
         fft_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge hclk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (pw_we) begin
            we_cnt++;
            if (exp_bin.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL pw_write_unexpected: addr 0x%0h data 0x%0h, no write expected at %0t",
                        pw_addr, pw_wdata, $time);
            end else begin
               mon_bin = exp_bin.pop_front();
               check("pw_write", {pw_addr, pw_wdata}, mon_bin);
            end
         end
         if (stall_q) begin
            check("stall_valid", fft_valid, 1);
            check("stall_data", fft_data, stall_data);
         end
         if (fft_valid && fft_ready) begin
            if (exp_samp.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sample_unexpected: data 0x%0h, no sample expected at %0t", fft_data, $time);
            end else begin
               mon_samp = exp_samp.pop_front();
               check("sample", fft_data, mon_samp);
            end
         end
         stall_q    = fft_valid && !fft_ready;
         stall_data = fft_data;
      end
   end

   task automatic push_samples(input logic [ADDR_W-1:0] base);
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < FFT_N; i++) begin
         a = base + ADDR_W'(i);
         exp_samp.push_back(32'(a));
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] base);
      @(posedge hclk); #1;
      rd_base = base;
      start   = 1'b1;
      @(posedge hclk); #1;
      start   = 1'b0;
      rd_base = ~base;
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int          cyc;
      int          done0;
      int          we0;
      logic [31:0] d;
      rnd_ready = v.rnd;
      push_samples(v.base);
      pulse_start(v.base);
      check("start_busy", busy, 1);
      check("start_rd_en", rd_en, 1);
      check("start_rd_addr", rd_addr, v.base);
      check("start_err_last_clr", err_last, 0);
      check("start_err_stray_clr", err_stray, 0);
      @(posedge hclk); #1;
      check("first_valid", fft_valid, 1);
      check("first_data", fft_data, 32'(v.base));

      cyc = 0;
      while (exp_samp.size() != 0 && cyc < 4000) begin
         @(posedge hclk); #1;
         cyc++;
         if (v.mid_start) begin
            start = (cyc == 40);
            if (cyc == 40) rd_base = 10'd500;
         end
      end
      start = 1'b0;
      check("samples_drained", exp_samp.size(), 0);
      exp_samp.delete();

      done0 = done_cnt;
      we0   = we_cnt;
      for (int i = 0; i < FFT_N; i++) begin
         @(posedge hclk); #1;
         d        = 32'h3F80_0000 | 32'(idx << 12) | 32'(i);
         pw_valid = 1'b1;
         pw_data  = d;
         pw_last  = (v.last_mode == 0 && i == 255) || (v.last_mode == 1 && i == 200);
         if (i < NBINS) exp_bin.push_back({8'(i), d});
      end
      @(posedge hclk); #1;
      pw_valid = 1'b0;
      pw_last  = 1'b0;
      check("done_pulse", done, 1);
      check("busy_fall", busy, 0);
      @(posedge hclk); #1;
      check("done_single_cycle", done, 0);
      exp_frames++;
      check("done_count", done_cnt - done0, 1);
      check("pw_we_count", we_cnt - we0, NBINS);
      check("bins_consumed", exp_bin.size(), 0);
      check("frame_cnt", frame_cnt, 16'(exp_frames));
      check("err_last", err_last, v.exp_err);
      check("err_stray_frame", err_stray, 0);
      exp_bin.delete();
   endtask

   task automatic abort_seq();
      int cyc;
      int done0;
      int we0;
      rnd_ready = 1'b0;
      repeat (2) @(posedge hclk);
      done0 = done_cnt;
      we0   = we_cnt;
      push_samples(10'h050);
      pulse_start(10'h050);
      cyc = 0;
      while (exp_samp.size() > FFT_N - 100 && cyc < 1000) begin
         @(posedge hclk); #1;
         cyc++;
      end
      check("abort_reached_sample_100", exp_samp.size() <= FFT_N - 100, 1);
      abort = 1'b1;
      @(posedge hclk); #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_no_done", done, 0);
      check("abort_rd_en", rd_en, 0);
      exp_samp.delete();
      for (int k = 0; k < 3; k++) begin
         @(posedge hclk); #1;
         pw_valid = 1'b1;
         pw_data  = 32'hDEAD_0000 | 32'(k);
      end
      @(posedge hclk); #1;
      pw_valid = 1'b0;
      check("stray_err", err_stray, 1);
      check("stray_err_last", err_last, 0);
      check("abort_frame_cnt", frame_cnt, 16'(exp_frames));
      check("abort_done_count", done_cnt - done0, 0);
      check("stray_no_write", we_cnt - we0, 0);
      check("abort_fft_valid", fft_valid, 0);

      // start and abort together from IDLE: abort wins, nothing is latched or cleared.
      @(posedge hclk); #1;
      start   = 1'b1;
      abort   = 1'b1;
      rd_base = 10'h123;
      @(posedge hclk); #1;
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_rd_en", rd_en, 0);
      check("start_abort_stray_kept", err_stray, 1);
      @(posedge hclk); #1;
      check("start_abort_still_idle", busy, 0);
   endtask

   task automatic reset_seq();
      int done0;
      rnd_ready = 1'b0;
      push_samples(10'd3);
      pulse_start(10'd3);
      repeat (30) @(posedge hclk);
      done0 = done_cnt;
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_fft_valid", fft_valid, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_done", done, 0);
      check("rst_pw_ready", pw_ready, 1);
      exp_samp.delete();
      exp_frames = 0;
      @(posedge hclk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge hclk);
      #1;
      check("rst_no_done", done_cnt - done0, 0);
      check("rst_still_idle", busy, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      rd_base  = '0;
      pw_valid = 1'b0;
      pw_last  = 1'b0;
      pw_data  = '0;

      vecs[0] = '{base: 10'd0,    rnd: 1'b0, last_mode: 0, mid_start: 1'b0, exp_err: 1'b0};
      vecs[1] = '{base: 10'd1000, rnd: 1'b0, last_mode: 0, mid_start: 1'b0, exp_err: 1'b0};
      vecs[2] = '{base: 10'd37,   rnd: 1'b1, last_mode: 0, mid_start: 1'b1, exp_err: 1'b0};
      vecs[3] = '{base: 10'd5,    rnd: 1'b0, last_mode: 1, mid_start: 1'b0, exp_err: 1'b1};
      vecs[4] = '{base: 10'd900,  rnd: 1'b0, last_mode: 2, mid_start: 1'b0, exp_err: 1'b1};
      vecs[5] = '{base: 10'd1020, rnd: 1'b1, last_mode: 0, mid_start: 1'b0, exp_err: 1'b0};

      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err_last", err_last, 0);
      check("reset_err_stray", err_stray, 0);
      check("reset_frame_cnt", frame_cnt, 0);
      check("reset_rd_en", rd_en, 0);
      check("reset_rd_addr", rd_addr, 0);
      check("reset_fft_valid", fft_valid, 0);
      check("reset_fft_data", fft_data, 0);
      check("reset_pw_we", pw_we, 0);
      check("reset_pw_ready", pw_ready, 1);
      @(posedge hclk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_frame(vecs[i], i);
      abort_seq();
      run_frame(vecs[0], 6);
      reset_seq();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the FFT power-spectrum datapath. On a CPU start command it streams one FFT_N-sample frame from the circular sample buffer into the power-spectrum pipeline, collects the returned power bins, and writes the first NBINS bins (DC..Nyquist) to the power buffer. It also checks frame alignment and raises a done pulse for the MFCC stage and the interrupt logic. It sits between the AHB-visible sample/power RAMs and the power-spectrum pipeline.

## Interface
- FFT_N, 256, samples per frame and bins returned per frame
- NBINS, 129, bins written to power buffer (0..NBINS-1); rest discarded
- ADDR_W, 10, sample buffer address width (circular, 2^ADDR_W words)
- hclk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next cycle
- rd_base  in  ADDR_W  first sample address, sampled on accepted start
- busy  out  1  high in FEED/DRAIN
- done  out  1  one-cycle pulse at frame completion
- err_last  out  1  sticky: tlast misaligned in a frame; cleared on accepted start
- err_stray  out  1  sticky: power bin received in IDLE; cleared on accepted start
- frame_cnt  out  16  completed frames, wraps
- rd_en  out  1  sample RAM read strobe
- rd_addr  out  ADDR_W  sample RAM address
- rd_data  in  32  sample RAM data, valid exactly 1 cycle after rd_en
- fft_data  out  32  sample to pipeline
- fft_valid  out  1  sample valid
- fft_ready  in  1  pipeline accepts sample
- pw_data  in  32  power bin from pipeline (float32)
- pw_valid  in  1  bin valid
- pw_last  in  1  last bin of frame
- pw_ready  out  1  constant 1 after reset
- pw_we  out  1  power RAM write strobe
- pw_addr  out  8  bin index
- pw_wdata  out  32  bin value

## Operation
- States: IDLE, FEED, DRAIN.
  - IDLE→FEED on start: latch rd_base, clear feed/read/bin counters and error flags.
  - FEED→DRAIN once FFT_N samples are accepted (fft_valid & fft_ready).
  - DRAIN→IDLE once bin FFT_N-1 is accepted; done pulses on that transition and frame_cnt increments.
  - abort in any state → IDLE; counters cleared; done not asserted; frame_cnt unchanged.
- Read side: rd_addr = rd_base + read_count, modulo 2^ADDR_W. Wrap past 2^ADDR_W-1 to 0 is required.
- Skid FIFO: read data enters a 2-entry skid FIFO. rd_en is issued only when (occupancy + in-flight reads) < 2 and read_count < FFT_N, so backpressure never drops data.
- fft_data/fft_valid come from the FIFO head.
- Bin side, accepted only in FEED/DRAIN:
  - bin_count increments per accepted bin.
  - pw_we = 1 only when bin_count < NBINS; pw_addr = bin_count, pw_wdata = pw_data.
  - Bins received in FEED are legal (pipeline overlap) and are counted.
- Alignment: err_last is set when pw_last=1 with bin_count≠FFT_N-1, or pw_last=0 with bin_count=FFT_N-1. The frame still ends on the count.
- Bins in IDLE (e.g. after abort) are accepted, not written, and set err_stray.
- start while busy is ignored. start and abort in the same cycle: abort wins.

## Timing
- Reset values: all outputs 0 except pw_ready=1; state IDLE; frame_cnt=0.
- start accepted at edge N → busy=1 and first rd_en in cycle N+1; fft_valid earliest in N+2.
- With fft_ready held high: one sample per cycle, no bubbles; FEED lasts FFT_N+1 cycles after start.
- fft_valid is held with stable fft_data until accepted. It never deasserts without acceptance except on abort or reset.
- pw_we is combinational from pw_valid in FEED/DRAIN (zero added latency); pw_addr and pw_wdata change with it.
- done is asserted in the cycle after the bin FFT_N-1 handshake; busy falls in the same cycle.
- Asynchronous reset mid-frame clears everything immediately; no done.

## Structure
- Shared package fft_pkg: FFT_N, NBINS, state encoding (ctrl_state_t), float32 width constant.
- One sub-module, fft_skid_fifo: 2-entry, 32-bit, with valid/ready and occupancy output.
- Counter and FSM logic stay in fft_frame_ctrl.

## Test plan
- Sample RAM holds addr value; rd_base=0, fft_ready=1, model returns 256 bins with last on #255 → 256 samples 0..255 sent in order; pw_we exactly 129 times with addr 0..128; done once; frame_cnt=1.
- rd_base=1000, ADDR_W=10 → samples 1000..1023 then 0..231; no gap or duplicate.
- Random fft_ready (50% low) → all 256 samples delivered exactly once and in order; fft_data stable while valid & !ready.
- pw_last at bin 200 (and, separately, absent at bin 255) → err_last=1; done still after bin 255; err_last clears on next start.
- abort at sample 100 followed by 3 stray bins in IDLE → busy=0 next cycle; no done; frame_cnt unchanged; err_stray=1; no pw_we.
- start pulsed while busy, and start+abort in the same cycle from IDLE → ignored / remains IDLE respectively.
